// File: rtl/img_pkg.sv
// Shared constants and FSM state type for the VGA-window to CNN-image pooling path.
package img_pkg;

  localparam int unsigned WIN        = 224;
  localparam int unsigned POOL       = 8;
  localparam int unsigned OUT_DIM    = WIN / POOL;
  localparam int unsigned PIX_W      = 8;
  localparam int unsigned COORD_W    = 8;
  localparam int unsigned IMG_ADDR_W = 10;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    ACCUM,
    FIN
  } pool_state_t;

endpackage

// File: rtl/pixel_avg_pool_acc_bank.sv
// One running column-sum register per output column; combinational load-or-add path, one write per cycle.
module pool_acc_bank
  import img_pkg::*;
#(
  parameter int unsigned DEPTH = OUT_DIM,
  parameter int unsigned IDX_W = 5,
  parameter int unsigned PIX_W = 8,
  parameter int unsigned ACC_W = 14
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic             i_load,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [PIX_W-1:0] i_pix,
  output logic [ACC_W-1:0] o_sum_c
);

  logic [ACC_W-1:0] r_acc [DEPTH];

  // First pixel of a pooling cell restarts the sum, so no clear pass is needed.
  assign o_sum_c = i_load ? ACC_W'(i_pix) : r_acc[i_idx] + ACC_W'(i_pix);

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_acc[i_idx] <= o_sum_c;
    end
  end

endmodule

// File: rtl/pixel_avg_pool.sv
// Averages each POOLxPOOL cell of the capture window into one image_mem write, raster order.
module pixel_avg_pool
  import img_pkg::*;
#(
  parameter int unsigned WIN    = img_pkg::WIN,
  parameter int unsigned POOL   = img_pkg::POOL,
  parameter int unsigned PIX_W  = img_pkg::PIX_W,
  parameter bit          INVERT = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_pix_vld,
  input  logic [PIX_W-1:0]      i_pix_color,
  input  logic [COORD_W-1:0]    i_pix_haddr,
  input  logic [COORD_W-1:0]    i_pix_vaddr,
  output logic                  o_wr_en,
  output logic [IMG_ADDR_W-1:0] o_wr_addr,
  output logic [PIX_W-1:0]      o_wr_data,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int unsigned OUT_EDGE  = WIN / POOL;
  localparam int unsigned LOG2_POOL = $clog2(POOL);
  localparam int unsigned ACC_W     = PIX_W + 2 * LOG2_POOL;
  localparam int unsigned IDX_W     = (OUT_EDGE > 1) ? $clog2(OUT_EDGE) : 1;

  pool_state_t        r_state;
  logic               w_in_range;
  logic               w_origin;
  logic               w_last;
  logic               w_cell_first;
  logic               w_cell_last;
  logic               w_proc;
  logic               w_emit;
  logic [COORD_W-1:0] w_hcell;
  logic [COORD_W-1:0] w_vcell;
  logic [ACC_W-1:0]   w_sum;
  logic [PIX_W-1:0]   w_avg;

  assign w_in_range   = (i_pix_haddr < COORD_W'(WIN)) && (i_pix_vaddr < COORD_W'(WIN));
  assign w_origin     = (i_pix_haddr == '0) && (i_pix_vaddr == '0);
  assign w_last       = (i_pix_haddr == COORD_W'(WIN - 1)) && (i_pix_vaddr == COORD_W'(WIN - 1));
  assign w_hcell      = i_pix_haddr >> LOG2_POOL;
  assign w_vcell      = i_pix_vaddr >> LOG2_POOL;
  assign w_cell_first = (i_pix_haddr[LOG2_POOL-1:0] == '0) && (i_pix_vaddr[LOG2_POOL-1:0] == '0);
  assign w_cell_last  = (&i_pix_haddr[LOG2_POOL-1:0]) && (&i_pix_vaddr[LOG2_POOL-1:0]);

  // Only the frame origin may open a capture, so a start mid-frame waits for the next frame.
  assign w_proc = i_pix_vld && w_in_range &&
                  ((r_state == ACCUM) || ((r_state == ARM) && w_origin));
  assign w_emit = w_proc && w_cell_last;
  assign w_avg  = PIX_W'(w_sum >> (2 * LOG2_POOL));

  pool_acc_bank #(
    .DEPTH (OUT_EDGE),
    .IDX_W (IDX_W),
    .PIX_W (PIX_W),
    .ACC_W (ACC_W)
  ) u_acc_bank (
    .clk     (clk),
    .i_we    (w_proc),
    .i_load  (w_cell_first),
    .i_idx   (IDX_W'(w_hcell)),
    .i_pix   (i_pix_color),
    .o_sum_c (w_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      o_wr_en   <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      o_wr_en <= w_emit;
      o_done  <= 1'b0;
      if (w_emit) begin
        o_wr_addr <= IMG_ADDR_W'(w_vcell) * IMG_ADDR_W'(OUT_EDGE) + IMG_ADDR_W'(w_hcell);
        o_wr_data <= INVERT ? ~w_avg : w_avg;
      end
      case (r_state)
        // A start coinciding with the done pulse is dropped.
        IDLE: begin
          if (i_start && !o_done) begin
            r_state <= ARM;
            o_busy  <= 1'b1;
          end
        end
        ARM: begin
          if (w_proc) begin
            r_state <= ACCUM;
          end
        end
        ACCUM: begin
          if (w_proc && w_last) begin
            r_state <= FIN;
          end
        end
        FIN: begin
          o_done  <= 1'b1;
          o_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_avg_pool.sv
// Bench for pixel_avg_pool on a reduced 48x48 window: inverted and plain instances share one pixel stream.
module tb_pixel_avg_pool;

  localparam int WIN  = 48;
  localparam int POOL = 8;
  localparam int OUT  = WIN / POOL;
  localparam int NW   = OUT * OUT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       vld = 1'b0;
  logic [7:0] color = '0;
  logic [7:0] haddr = '0;
  logic [7:0] vaddr = '0;

  logic       inv_wr_en, pos_wr_en, inv_busy, pos_busy, inv_done, pos_done;
  logic [9:0] inv_wr_addr, pos_wr_addr;
  logic [7:0] inv_wr_data, pos_wr_data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int img [WIN][WIN];
  int exp_avg [NW];
  int q_addr[$], q_addr_pos[$], q_dinv[$], q_dpos[$];
  int done_cnt = 0;
  int done_cyc = -1;
  int last_wr_cyc = -1;

  pixel_avg_pool #(.WIN(WIN), .POOL(POOL), .PIX_W(8), .INVERT(1'b1)) dut_inv (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_pix_vld(vld), .i_pix_color(color),
    .i_pix_haddr(haddr), .i_pix_vaddr(vaddr), .o_wr_en(inv_wr_en), .o_wr_addr(inv_wr_addr),
    .o_wr_data(inv_wr_data), .o_busy(inv_busy), .o_done(inv_done)
  );

  pixel_avg_pool #(.WIN(WIN), .POOL(POOL), .PIX_W(8), .INVERT(1'b0)) dut_pos (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_pix_vld(vld), .i_pix_color(color),
    .i_pix_haddr(haddr), .i_pix_vaddr(vaddr), .o_wr_en(pos_wr_en), .o_wr_addr(pos_wr_addr),
    .o_wr_data(pos_wr_data), .o_busy(pos_busy), .o_done(pos_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Write/done capture, sampled mid-cycle.
  always @(negedge clk) begin
    if (inv_wr_en) begin
      q_addr.push_back(int'(inv_wr_addr));
      q_dinv.push_back(int'(inv_wr_data));
      last_wr_cyc = cyc;
    end
    if (pos_wr_en) begin
      q_addr_pos.push_back(int'(pos_wr_addr));
      q_dpos.push_back(int'(pos_wr_data));
    end
    if (inv_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    q_addr.delete();
    q_addr_pos.delete();
    q_dinv.delete();
    q_dpos.delete();
    done_cnt = 0;
    done_cyc = -1;
    last_wr_cyc = -1;
  endtask

  task automatic do_start();
    start = 1'b1;
    vld   = 1'b0;
    tick();
    start = 1'b0;
  endtask

  function automatic int pix_val(input int pat, input int x);
    case (pat)
      0:       return 200;
      1:       return x;
      2:       return 255;
      default: return int'($urandom_range(255));
    endcase
  endfunction

  // Truncated mean of every cell of img, indexed by output raster address.
  function automatic void build_model();
    for (int b = 0; b < NW; b++) begin
      int sum = 0;
      for (int dy = 0; dy < POOL; dy++)
        for (int dx = 0; dx < POOL; dx++)
          sum += img[(b / OUT) * POOL + dy][(b % OUT) * POOL + dx];
      exp_avg[b] = sum / (POOL * POOL);
    end
  endfunction

  // One raster frame; optional idle gaps, out-of-window pixels, a start pulse or a reset at a pixel index.
  task automatic stream_frame(input int pat, input int gap_pct, input int oob_pct,
                              input int start_idx, input int rst_idx);
    for (int y = 0; y < WIN; y++) begin
      for (int x = 0; x < WIN; x++) begin
        start = 1'b0;
        if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
          vld = 1'b0; haddr = 8'($urandom); vaddr = 8'($urandom); color = 8'($urandom);
          tick();
        end
        if (oob_pct > 0 && int'($urandom_range(99)) < oob_pct) begin
          vld = 1'b1; color = 8'($urandom);
          if ($urandom_range(1) == 1) begin
            haddr = 8'($urandom_range(255, WIN)); vaddr = 8'($urandom);
          end else begin
            haddr = 8'($urandom); vaddr = 8'($urandom_range(255, WIN));
          end
          tick();
        end
        if (y * WIN + x == rst_idx) begin
          vld = 1'b0;
          rst_n = 1'b0;
          return;
        end
        img[y][x] = pix_val(pat, x);
        vld   = 1'b1;
        haddr = 8'(x);
        vaddr = 8'(y);
        color = 8'(img[y][x]);
        start = (y * WIN + x == start_idx);
        tick();
      end
    end
    vld = 1'b0;
    start = 1'b0;
  endtask

  task automatic settle();
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (inv_wr_en !== 1'b0 || pos_wr_en !== 1'b0) begin
      errors++; $display("FAIL reset wr_en: got %b/%b, expected 0/0", inv_wr_en, pos_wr_en);
    end
    checks++;
    if (inv_wr_addr !== 10'd0 || inv_wr_data !== 8'd0 || pos_wr_data !== 8'd0) begin
      errors++; $display("FAIL reset addr/data: got %0d/%0d/%0d, expected 0/0/0", inv_wr_addr, inv_wr_data, pos_wr_data);
    end
    checks++;
    if (inv_busy !== 1'b0 || inv_done !== 1'b0) begin
      errors++; $display("FAIL reset busy/done: got %b/%b, expected 0/0", inv_busy, inv_done);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_uniform();
    do_start();
    checks++;
    if (inv_busy !== 1'b1) begin
      errors++; $display("FAIL uniform busy after start: got %b, expected 1", inv_busy);
    end
    clear_mon();
    stream_frame(0, 0, 0, -1, -1);
    settle();
    build_model();
    checks++;
    if (q_addr.size() != NW || q_dpos.size() != NW) begin
      errors++; $display("FAIL uniform write count: got %0d/%0d, expected %0d", q_addr.size(), q_dpos.size(), NW);
    end
    for (int i = 0; i < NW && i < q_addr.size() && i < q_dpos.size(); i++) begin
      checks++;
      if (q_addr[i] !== i || q_addr_pos[i] !== i || q_dinv[i] !== 55 || q_dpos[i] !== exp_avg[i]) begin
        errors++;
        $display("FAIL uniform write %0d: addr=%0d inv=%0d avg=%0d, expected addr=%0d inv=55 avg=%0d",
                 i, q_addr[i], q_dinv[i], q_dpos[i], i, exp_avg[i]);
      end
    end
    checks++;
    if (done_cnt !== 1 || done_cyc !== last_wr_cyc + 1) begin
      errors++; $display("FAIL uniform done: got %0d pulses at cycle %0d, expected 1 at %0d", done_cnt, done_cyc, last_wr_cyc + 1);
    end
    checks++;
    if (inv_busy !== 1'b0) begin
      errors++; $display("FAIL uniform busy after done: got %b, expected 0", inv_busy);
    end
  endtask

  task automatic test_ramp();
    do_start();
    clear_mon();
    stream_frame(1, 0, 10, -1, -1);
    settle();
    build_model();
    checks++;
    if (q_addr.size() != NW || q_dpos.size() != NW) begin
      errors++; $display("FAIL ramp write count: got %0d/%0d, expected %0d", q_addr.size(), q_dpos.size(), NW);
    end
    for (int i = 0; i < NW && i < q_addr.size() && i < q_dpos.size(); i++) begin
      checks++;
      if (q_addr[i] !== i || q_dinv[i] !== 252 - 8 * (i % OUT) || q_dpos[i] !== exp_avg[i]) begin
        errors++;
        $display("FAIL ramp write %0d: addr=%0d inv=%0d avg=%0d, expected addr=%0d inv=%0d avg=%0d",
                 i, q_addr[i], q_dinv[i], q_dpos[i], i, 252 - 8 * (i % OUT), exp_avg[i]);
      end
    end
  endtask

  task automatic test_saturate_gaps();
    int ref_addr[$], ref_data[$];
    do_start();
    clear_mon();
    stream_frame(2, 0, 0, -1, -1);
    settle();
    checks++;
    if (q_dpos.size() != NW || q_dinv.size() != NW) begin
      errors++; $display("FAIL white write count: got %0d/%0d, expected %0d", q_dpos.size(), q_dinv.size(), NW);
    end
    for (int i = 0; i < NW && i < q_dpos.size() && i < q_dinv.size(); i++) begin
      checks++;
      if (q_dpos[i] !== 255 || q_dinv[i] !== 0) begin
        errors++; $display("FAIL white write %0d: avg=%0d inv=%0d, expected avg=255 inv=0", i, q_dpos[i], q_dinv[i]);
      end
    end
    ref_addr = q_addr_pos;
    ref_data = q_dpos;
    do_start();
    clear_mon();
    stream_frame(2, 30, 10, -1, -1);
    settle();
    checks++;
    if (q_addr_pos != ref_addr || q_dpos != ref_data) begin
      errors++; $display("FAIL gap sequence: got %0d writes differing from %0d-write gap-free run", q_addr_pos.size(), ref_addr.size());
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++; $display("FAIL gap done: got %0d pulses, expected 1", done_cnt);
    end
  endtask

  task automatic test_mid_frame_start();
    clear_mon();
    stream_frame(3, 0, 0, 10 * WIN + 20, -1);
    settle();
    checks++;
    if (q_addr.size() != 0 || inv_busy !== 1'b1) begin
      errors++; $display("FAIL midstart partial: got %0d writes busy=%b, expected 0 writes busy=1", q_addr.size(), inv_busy);
    end
    clear_mon();
    stream_frame(3, 20, 5, -1, -1);
    settle();
    build_model();
    checks++;
    if (q_addr.size() != NW || q_dpos.size() != NW || done_cnt !== 1) begin
      errors++; $display("FAIL midstart frame: got %0d writes %0d done, expected %0d writes 1 done", q_addr.size(), done_cnt, NW);
    end
    for (int i = 0; i < NW && i < q_addr.size() && i < q_dpos.size(); i++) begin
      checks++;
      if (q_addr[i] !== i || q_dinv[i] !== 255 - exp_avg[i] || q_dpos[i] !== exp_avg[i]) begin
        errors++;
        $display("FAIL midstart write %0d: addr=%0d inv=%0d avg=%0d, expected addr=%0d inv=%0d avg=%0d",
                 i, q_addr[i], q_dinv[i], q_dpos[i], i, 255 - exp_avg[i], exp_avg[i]);
      end
    end
  endtask

  task automatic test_double_start();
    do_start();
    clear_mon();
    stream_frame(3, 10, 0, 20 * WIN + 5, -1);
    settle();
    build_model();
    checks++;
    if (q_addr.size() != NW || done_cnt !== 1 || inv_busy !== 1'b0) begin
      errors++; $display("FAIL double start: got %0d writes %0d done busy=%b, expected %0d writes 1 done busy=0",
                         q_addr.size(), done_cnt, inv_busy, NW);
    end
    for (int i = 0; i < NW && i < q_addr.size() && i < q_dpos.size(); i++) begin
      checks++;
      if (q_addr[i] !== i || q_dpos[i] !== exp_avg[i]) begin
        errors++; $display("FAIL double start write %0d: addr=%0d avg=%0d, expected addr=%0d avg=%0d", i, q_addr[i], q_dpos[i], i, exp_avg[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    do_start();
    clear_mon();
    stream_frame(3, 0, 0, -1, 30 * WIN);
    #1;
    checks++;
    if (inv_busy !== 1'b0 || inv_wr_en !== 1'b0 || inv_wr_addr !== 10'd0 || inv_wr_data !== 8'd0 || pos_wr_data !== 8'd0) begin
      errors++; $display("FAIL midreset outputs: got busy=%b wr_en=%b addr=%0d data=%0d/%0d, expected all 0",
                         inv_busy, inv_wr_en, inv_wr_addr, inv_wr_data, pos_wr_data);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    clear_mon();
    stream_frame(3, 0, 0, -1, -1);
    settle();
    checks++;
    if (q_addr.size() != 0 || done_cnt !== 0 || inv_busy !== 1'b0) begin
      errors++; $display("FAIL midreset resume: got %0d writes %0d done busy=%b, expected 0 0 0", q_addr.size(), done_cnt, inv_busy);
    end
    do_start();
    clear_mon();
    stream_frame(3, 15, 5, -1, -1);
    settle();
    build_model();
    checks++;
    if (q_addr.size() != NW || q_dpos.size() != NW || done_cnt !== 1) begin
      errors++; $display("FAIL postreset frame: got %0d writes %0d done, expected %0d writes 1 done", q_addr.size(), done_cnt, NW);
    end
    for (int i = 0; i < NW && i < q_addr.size() && i < q_dpos.size(); i++) begin
      checks++;
      if (q_addr[i] !== i || q_dinv[i] !== 255 - exp_avg[i] || q_dpos[i] !== exp_avg[i]) begin
        errors++;
        $display("FAIL postreset write %0d: addr=%0d inv=%0d avg=%0d, expected addr=%0d inv=%0d avg=%0d",
                 i, q_addr[i], q_dinv[i], q_dpos[i], i, 255 - exp_avg[i], exp_avg[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_ramp();
    test_saturate_gaps();
    test_mid_frame_start();
    test_double_start();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
